// File: rtl/mems_dac_sequencer.sv
// Streams 24-bit command ROM words to a MEMS DAC over sclk/sync_n/sdo, MSB first; MEMS_INIT_EN adds a post-reset init of words 0..1.
// Latency: 2+48*CLK_DIV+SYNC_GAP clk per word; no backpressure, start is dropped while busy or on the done cycle.
module mems_dac_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  addr,
  input  logic [23:0] rom_data,
  output logic        sclk,
  output logic        sync_n,
  output logic        sdo,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(SYNC_GAP - 1);
  localparam logic [2:0] FIRST_IDX = 3'd2;
  localparam logic [2:0] LAST_IDX  = 3'd6;

`ifdef MEMS_INIT_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP, INIT_FETCH, INIT_LOAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} state_t;
`endif

  state_t      state;
  logic [2:0]  idx;
  logic [23:0] sreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
`ifdef MEMS_INIT_EN
  logic        init_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      addr    <= '0;
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk    <= 1'b1;
      sync_n  <= 1'b1;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MEMS_INIT_EN
      init_pend <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MEMS_INIT_EN
          if (init_pend) begin
            state <= INIT_FETCH;
            idx   <= 3'd0;
            addr  <= 4'd0;
            busy  <= 1'b1;
          end else
`endif
          if (start && !busy && !done) begin
            state <= FETCH;
            idx   <= FIRST_IDX;
            addr  <= {1'b0, FIRST_IDX};
            busy  <= 1'b1;
          end
        end

        FETCH: state <= LOAD;

`ifdef MEMS_INIT_EN
        INIT_FETCH: state <= INIT_LOAD;

        LOAD, INIT_LOAD: begin
`else
        LOAD: begin
`endif
          sreg    <= rom_data;
          sdo     <= rom_data[23];
          sync_n  <= 1'b0;
          sclk    <= 1'b1;
          bit_cnt <= '0;
          div_cnt <= '0;
          state   <= SHIFT;
        end

        // sclk falls mid-bit for the DAC to sample; each rise presents the next bit
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == 5'd23) begin
              sclk   <= 1'b1;
              sync_n <= 1'b1;
              sdo    <= 1'b0;
              state  <= GAP;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
              sreg    <= {sreg[22:0], sreg[23]};
              sdo     <= sreg[22];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
`ifdef MEMS_INIT_EN
            if (init_pend) begin
              if (idx == 3'd0) begin
                idx   <= 3'd1;
                addr  <= 4'd1;
                state <= INIT_FETCH;
              end else begin
                init_pend <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
              end
            end else
`endif
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              addr  <= {1'b0, idx + 3'd1};
              state <= FETCH;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mems_dac_sequencer.sv
// Directed bench: two DUT instances (CLK_DIV=2/SYNC_GAP=4 and CLK_DIV=1/SYNC_GAP=1) with a registered ROM model.
module tb_mems_dac_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [3:0] addr_a, addr_b;
  logic [23:0] rom_data_a, rom_data_b;
  logic sclk_a, sync_n_a, sdo_a, busy_a, done_a;
  logic sclk_b, sync_n_b, sdo_b, busy_b, done_b;

  always #5 clk = ~clk;

  mems_dac_sequencer #(.CLK_DIV(2), .SYNC_GAP(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .rom_data(rom_data_a),
    .sclk(sclk_a), .sync_n(sync_n_a), .sdo(sdo_a), .busy(busy_a), .done(done_a)
  );

  mems_dac_sequencer #(.CLK_DIV(1), .SYNC_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .rom_data(rom_data_b),
    .sclk(sclk_b), .sync_n(sync_n_b), .sdo(sdo_b), .busy(busy_b), .done(done_b)
  );

  logic [23:0] rom [16];
  logic [23:0] exp_w [5];

  always @(posedge clk) begin
    rom_data_a <= rom[addr_a];
    rom_data_b <= rom[addr_b];
  end

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  logic sclk_s [2], sync_s [2], sdo_s [2], busy_s [2], done_s [2];
  assign sclk_s[0] = sclk_a;   assign sclk_s[1] = sclk_b;
  assign sync_s[0] = sync_n_a; assign sync_s[1] = sync_n_b;
  assign sdo_s[0]  = sdo_a;    assign sdo_s[1]  = sdo_b;
  assign busy_s[0] = busy_a;   assign busy_s[1] = busy_b;
  assign done_s[0] = done_a;   assign done_s[1] = done_b;

  // Bus monitor: captures sdo on every falling sclk inside a sync_n low window
  logic [23:0] cap [2];
  int nbits [2], lowlen [2], widx [2], ndone [2], fall_t [2], sclk_per [2];
  logic sclk_q [2], sync_q [2];
  logic [23:0] words [2][64];
  int lens [2][64];
  int wbits [2][64];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; nbits[i] = 0; lowlen[i] = 0; widx[i] = 0; ndone[i] = 0;
      fall_t[i] = 0; sclk_per[i] = 0; sclk_q[i] = 1'b1; sync_q[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sync_s[i] === 1'b0) begin
        lowlen[i]++;
        if (sclk_q[i] === 1'b1 && sclk_s[i] === 1'b0) begin
          cap[i] = {cap[i][22:0], sdo_s[i]};
          nbits[i]++;
          sclk_per[i] = pcnt - fall_t[i];
          fall_t[i] = pcnt;
        end
      end
      if (sync_q[i] === 1'b0 && sync_s[i] === 1'b1) begin
        words[i][widx[i] % 64] = cap[i];
        lens[i][widx[i] % 64]  = lowlen[i];
        wbits[i][widx[i] % 64] = nbits[i];
        widx[i]++;
        cap[i] = '0; lowlen[i] = 0; nbits[i] = 0;
      end
      if (done_s[i] === 1'b1) ndone[i]++;
      sclk_q[i] = sclk_s[i];
      sync_q[i] = sync_s[i];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done_s[i] !== 1'b1 && k < budget);
    chk(tag, int'(done_s[i]), 1);
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy_s[i] !== 1'b0 && k < budget);
    chk(tag, int'(busy_s[i]), 0);
  endtask

  task automatic check_frame(input int i, input int base, input int win, input string p);
    chk($sformatf("%s_nwords", p), widx[i] - base, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_word%0d", p, k), int'(words[i][(base + k) % 64]), int'(exp_w[k]));
      chk($sformatf("%s_win%0d", p, k), lens[i][(base + k) % 64], win);
      chk($sformatf("%s_bits%0d", p, k), wbits[i][(base + k) % 64], 24);
    end
  endtask

  int base, nd, t0, d1, d2, k;

  initial begin
    for (int n = 0; n < 16; n++) rom[n] = '0;
    rom[0] = 24'h280000;
    rom[1] = 24'h000000;
    rom[2] = 24'h188000;
    rom[3] = 24'h198000;
    rom[4] = 24'h1A8000;
    rom[5] = 24'h1B8000;
    rom[6] = 24'h380000;
    exp_w[0] = 24'h188000; exp_w[1] = 24'h198000; exp_w[2] = 24'h1A8000;
    exp_w[3] = 24'h1B8000; exp_w[4] = 24'h380000;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_sclk", int'(sclk_a), 1);
    chk("rst_sync_n", int'(sync_n_a), 1);
    chk("rst_sdo", int'(sdo_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    rst = 1'b0;

`ifdef MEMS_INIT_EN
    // Init: words 0 and 1 go out with busy high, no done; a start during init is dropped
    base = widx[0]; nd = ndone[0];
    repeat (5) @(negedge clk);
    chk("init_busy", int'(busy_a), 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(0, 400, "init_a_idle");
    wait_idle(1, 400, "init_b_idle");
    repeat (30) @(negedge clk);
    chk("init_nwords", widx[0] - base, 2);
    chk("init_word0", int'(words[0][base % 64]), 24'h280000);
    chk("init_word1", int'(words[0][(base + 1) % 64]), 24'h000000);
    chk("init_no_done", ndone[0] - nd, 0);
    chk("init_start_ignored", int'(busy_a), 0);
`else
    repeat (20) @(negedge clk);
    chk("noinit_busy", int'(busy_a), 0);
    chk("noinit_addr", int'(addr_a), 0);
    chk("noinit_nwords", widx[0], 0);
`endif

    // Basic frame, CLK_DIV=2 SYNC_GAP=4
    base = widx[0];
    @(negedge clk); start_a = 1'b1; t0 = pcnt + 1;
    @(negedge clk); start_a = 1'b0;
    chk("a_busy_rise", int'(busy_a), 1);
    chk("a_addr_fetch", int'(addr_a), 2);
    wait_done(0, 600, "a_done_seen");
    chk("a_done_lat", pcnt - t0, 510);
    chk("a_busy_at_done", int'(busy_a), 0);
    @(negedge clk);
    chk("a_done_pulse", int'(done_a), 0);
    check_frame(0, base, 96, "a");

    // Back-to-back: start held 600 cycles gives two frames; start on the done cycle is dropped
    repeat (5) @(negedge clk);
    base = widx[0]; nd = ndone[0]; d1 = -1;
    start_a = 1'b1; t0 = pcnt + 1;
    for (int j = 0; j < 600; j++) begin
      @(negedge clk);
      if (done_a === 1'b1) d1 = pcnt - t0;
    end
    start_a = 1'b0;
    wait_done(0, 600, "b2b_done2_seen");
    d2 = pcnt - t0;
    repeat (600) @(negedge clk);
    chk("b2b_done1_lat", d1, 510);
    chk("b2b_done2_lat", d2, 1022);
    chk("b2b_ndone", ndone[0] - nd, 2);
    chk("b2b_nwords", widx[0] - base, 10);
    chk("b2b_2nd_first", int'(words[0][(base + 5) % 64]), 24'h188000);

    // Minimum divider on instance B, then a start on the done cycle
    base = widx[1];
    @(negedge clk); start_b = 1'b1; t0 = pcnt + 1;
    @(negedge clk); start_b = 1'b0;
    wait_done(1, 400, "b_done_seen");
    chk("b_done_lat", pcnt - t0, 255);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_ign_busy0", int'(busy_b), 0);
    repeat (5) @(negedge clk);
    chk("b_ign_busy5", int'(busy_b), 0);
    chk("b_sclk_period", sclk_per[1], 2);
    check_frame(1, base, 48, "b");

    // Reset at bit 10 of word 3, then a fresh frame from word 2
    base = widx[0];
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    k = 0;
    while (!(widx[0] == base + 1 && nbits[0] == 10) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("mid_bit10", nbits[0], 10);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_sclk", int'(sclk_a), 1);
    chk("mid_sync_n", int'(sync_n_a), 1);
    chk("mid_busy", int'(busy_a), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle(0, 400, "mid_idle");
    repeat (3) @(negedge clk);
    base = widx[0];
    @(negedge clk); start_a = 1'b1; t0 = pcnt + 1;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, 600, "mid_done_seen");
    chk("mid_done_lat", pcnt - t0, 510);
    check_frame(0, base, 96, "mid");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
